// File: rtl/totd_deconv_ctrl_pkg.sv
// Shared sde_trigger definitions for the TOTD deconvolution controller:
// state encoding, 40 MHz phase constants, datapath widths and the ADC saturation code.
package totd_deconv_ctrl_pkg;

    localparam int COMPATIBILITY_TOTD_FD_BITS = 6;
    localparam int COMPATIBILITY_TOTD_FN_BITS = 12;
    localparam int ADC_WIDTH                  = 12;
    localparam int SAT_COUNT_BITS             = 16;

    localparam logic [1:0] PHASE_TICK  = 2'd0;
    localparam logic [1:0] PHASE_APPLY = 2'd2;
    localparam logic [1:0] PHASE_LAST  = 2'd2;

    localparam logic [ADC_WIDTH-1:0] ADC_SAT_VALUE = 12'd4095;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2
    } deconv_state_t;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [SAT_COUNT_BITS-1:0] sat_inc(input logic [SAT_COUNT_BITS-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/totd_deconv_ctrl_clk40_phase_gen.sv
// 40 MHz phase generator for the 120 MHz domain: ENABLE40 runs 0,1,2,0,...
// TICK marks the datapath update phase, APPLY_PHASE the configuration apply phase.
module clk40_phase_gen
    import totd_deconv_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    output logic [1:0] ENABLE40,
    output logic       TICK,
    output logic       APPLY_PHASE
);

    logic [1:0] phase;

    // Wrapping on >= the last phase also pulls an illegal 3 back into the sequence.
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase <= PHASE_TICK;
        end else if (phase >= PHASE_LAST) begin
            phase <= PHASE_TICK;
        end else begin
            phase <= phase + 2'd1;
        end
    end

    assign ENABLE40    = phase;
    assign TICK        = (phase == PHASE_TICK);
    assign APPLY_PHASE = (phase == PHASE_APPLY);

endmodule

// File: rtl/totd_deconv_ctrl.sv
// TOTD deconvolution controller: FD/FN reconfiguration on the 40 MHz apply phase and
// IDLE/FLUSH/RUN sequencing of DECONV_VALID. Define TOTD_DECONV_SAT_COUNT_EN for SAT_COUNT.
module totd_deconv_ctrl
    import totd_deconv_ctrl_pkg::*;
#(
    parameter int                                    FLUSH_TICKS = 7,
    parameter logic [COMPATIBILITY_TOTD_FD_BITS-1:0] FD_INIT     = 6'd58,
    parameter logic [COMPATIBILITY_TOTD_FN_BITS-1:0] FN_INIT     = 12'd16
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  ENABLE,
    input  logic                                  CFG_WR,
    input  logic [COMPATIBILITY_TOTD_FD_BITS-1:0] CFG_FD,
    input  logic [COMPATIBILITY_TOTD_FN_BITS-1:0] CFG_FN,
    input  logic [ADC_WIDTH-1:0]                  DATA_IN,
    output logic [1:0]                            ENABLE40,
    output logic [COMPATIBILITY_TOTD_FD_BITS-1:0] FD,
    output logic [COMPATIBILITY_TOTD_FN_BITS-1:0] FN,
    output logic                                  CFG_BUSY,
    output logic                                  DECONV_VALID
`ifdef TOTD_DECONV_SAT_COUNT_EN
    ,
    input  logic                                  SAT_CLR,
    output logic [SAT_COUNT_BITS-1:0]             SAT_COUNT
`endif
);

    localparam int CNT_W = (FLUSH_TICKS < 1) ? 1 : $clog2(FLUSH_TICKS + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_TICKS);

    logic tick;
    logic apply_phase;
    logic apply_now;

    logic [COMPATIBILITY_TOTD_FD_BITS-1:0] pend_fd;
    logic [COMPATIBILITY_TOTD_FN_BITS-1:0] pend_fn;
    logic [COMPATIBILITY_TOTD_FD_BITS-1:0] fd_q;
    logic [COMPATIBILITY_TOTD_FN_BITS-1:0] fn_q;
    logic                                  busy_q;

    deconv_state_t state;
    deconv_state_t state_next;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] flush_cnt_next;
    logic             valid_q;

    clk40_phase_gen u_phase (
        .CLK         (CLK),
        .RST         (RST),
        .ENABLE40    (ENABLE40),
        .TICK        (tick),
        .APPLY_PHASE (apply_phase)
    );

    assign apply_now = apply_phase & busy_q;

    // A write on the apply edge lands after the older pair is moved out, so busy stays set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_fd <= '0;
            pend_fn <= '0;
            fd_q    <= FD_INIT;
            fn_q    <= FN_INIT;
            busy_q  <= 1'b0;
        end else begin
            if (apply_now) begin
                fd_q <= pend_fd;
                fn_q <= pend_fn;
            end
            if (CFG_WR) begin
                pend_fd <= CFG_FD;
                pend_fn <= CFG_FN;
                busy_q  <= 1'b1;
            end else if (apply_now) begin
                busy_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            flush_cnt <= '0;
            valid_q   <= 1'b0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            valid_q   <= (state_next == RUN);
        end
    end

    // Dropping ENABLE wins over everything; a new FD/FN pair restarts the flush window.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        if (!ENABLE) begin
            state_next     = IDLE;
            flush_cnt_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next     = FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                end
                FLUSH: begin
                    if (apply_now) begin
                        flush_cnt_next = FLUSH_LOAD;
                    end else if (tick) begin
                        if (flush_cnt <= CNT_W'(1)) begin
                            state_next     = RUN;
                            flush_cnt_next = '0;
                        end else begin
                            flush_cnt_next = flush_cnt - CNT_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (apply_now) begin
                        state_next     = FLUSH;
                        flush_cnt_next = FLUSH_LOAD;
                    end
                end
                default: begin
                    state_next     = IDLE;
                    flush_cnt_next = '0;
                end
            endcase
        end
    end

    assign FD           = fd_q;
    assign FN           = fn_q;
    assign CFG_BUSY     = busy_q;
    assign DECONV_VALID = valid_q;

`ifdef TOTD_DECONV_SAT_COUNT_EN
    logic [SAT_COUNT_BITS-1:0] sat_cnt;

    // Counts saturated datapath samples only while the output is trusted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sat_cnt <= '0;
        end else if (SAT_CLR) begin
            sat_cnt <= '0;
        end else if ((state == RUN) && tick && (DATA_IN == ADC_SAT_VALUE)) begin
            sat_cnt <= sat_inc(sat_cnt);
        end
    end

    assign SAT_COUNT = sat_cnt;
`else
    logic unused_data_in;
    assign unused_data_in = ^DATA_IN;
`endif

endmodule

// File: tb/tb_totd_deconv_ctrl.sv
// Testbench for totd_deconv_ctrl; FD/FN applies are tracked through an expected-apply queue.
// Define TOTD_DECONV_SAT_COUNT_EN to include the saturation counter scenario.
module tb_totd_deconv_ctrl;
    import totd_deconv_ctrl_pkg::*;

    localparam logic [5:0]  FD_RST = 6'd58;
    localparam logic [11:0] FN_RST = 12'd16;

    typedef struct {
        logic [5:0]  fd;
        logic [11:0] fn;
        int          cyc;
    } apply_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ENABLE;
    logic        CFG_WR;
    logic [5:0]  CFG_FD;
    logic [11:0] CFG_FN;
    logic [11:0] DATA_IN;
    logic [1:0]  ENABLE40;
    logic [5:0]  FD;
    logic [11:0] FN;
    logic        CFG_BUSY;
    logic        DECONV_VALID;
`ifdef TOTD_DECONV_SAT_COUNT_EN
    logic        SAT_CLR;
    logic [15:0] SAT_COUNT;
`endif

    int checks = 0;
    int passed = 0;
    int cycle  = 0;

    logic        mon_on   = 1'b0;
    logic        rst_edge = 1'b0;
    logic [1:0]  m_phase  = 2'd0;
    logic        m_busy   = 1'b0;
    logic [5:0]  m_pfd    = '0;
    logic [11:0] m_pfn    = '0;
    logic [5:0]  last_fd  = '0;
    logic [11:0] last_fn  = '0;
    apply_t      sb_q[$];

    always #4 CLK = ~CLK;

    totd_deconv_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .ENABLE       (ENABLE),
        .CFG_WR       (CFG_WR),
        .CFG_FD       (CFG_FD),
        .CFG_FN       (CFG_FN),
        .DATA_IN      (DATA_IN),
        .ENABLE40     (ENABLE40),
        .FD           (FD),
        .FN           (FN),
        .CFG_BUSY     (CFG_BUSY),
        .DECONV_VALID (DECONV_VALID)
`ifdef TOTD_DECONV_SAT_COUNT_EN
        ,
        .SAT_CLR      (SAT_CLR),
        .SAT_COUNT    (SAT_COUNT)
`endif
    );

    // Advance one clock; the reference model pushes every expected FD/FN apply with its edge number.
    task automatic step();
        apply_t a;
        @(posedge CLK);
        cycle++;
        rst_edge = RST;
        if (RST) begin
            m_phase = 2'd0;
            m_busy  = 1'b0;
            m_pfd   = '0;
            m_pfn   = '0;
        end else begin
            if (m_phase == 2'd2 && m_busy) begin
                a.fd  = m_pfd;
                a.fn  = m_pfn;
                a.cyc = cycle;
                sb_q.push_back(a);
            end
            if (CFG_WR) begin
                m_pfd  = CFG_FD;
                m_pfn  = CFG_FN;
                m_busy = 1'b1;
            end else if (m_phase == 2'd2) begin
                m_busy = 1'b0;
            end
            m_phase = (m_phase == 2'd2) ? 2'd0 : m_phase + 2'd1;
        end
        #1;
    endtask

    task automatic wait_phase(input logic [1:0] p);
        for (int i = 0; i < 3 && m_phase != p; i++) step();
    endtask

    task automatic count_to_valid(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (DECONV_VALID === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    // Scoreboard monitor: phase sequence every cycle, FD/FN changes popped against the queue.
    always @(negedge CLK) begin
        apply_t e;
        if (mon_on) begin
            checks++;
            if (ENABLE40 !== m_phase)
                $display("[TB] FAIL phase: got %0d, want %0d at cycle %0d", ENABLE40, m_phase, cycle);
            else
                passed++;
            if (rst_edge) begin
                last_fd = FD;
                last_fn = FN;
            end else if (FD !== last_fd || FN !== last_fn) begin
                checks++;
                if (sb_q.size() == 0) begin
                    $display("[TB] FAIL apply_unexpected: got FD=%0d FN=%0d at cycle %0d, want no change",
                             FD, FN, cycle);
                end else begin
                    e = sb_q.pop_front();
                    if (FD !== e.fd || FN !== e.fn || cycle != e.cyc)
                        $display("[TB] FAIL apply: got FD=%0d FN=%0d at cycle %0d, want FD=%0d FN=%0d at cycle %0d",
                                 FD, FN, cycle, e.fd, e.fn, e.cyc);
                    else
                        passed++;
                end
                last_fd = FD;
                last_fn = FN;
            end
        end
    end

    task automatic test_reset();
        int exp_seq[6] = '{0, 1, 2, 0, 1, 2};
        RST = 1'b1; ENABLE = 1'b1; CFG_WR = 1'b1; CFG_FD = 6'd3; CFG_FN = 12'd3;
        step();
        mon_on = 1'b1;
        step();
        checks++; if (ENABLE40 !== 2'd0) $display("[TB] FAIL rst_phase: got %0d, want 0", ENABLE40); else passed++;
        checks++; if (FD !== FD_RST) $display("[TB] FAIL rst_fd: got %0d, want %0d", FD, FD_RST); else passed++;
        checks++; if (FN !== FN_RST) $display("[TB] FAIL rst_fn: got %0d, want %0d", FN, FN_RST); else passed++;
        checks++; if (CFG_BUSY !== 1'b0) $display("[TB] FAIL rst_busy: got %b, want 0", CFG_BUSY); else passed++;
        checks++; if (DECONV_VALID !== 1'b0) $display("[TB] FAIL rst_valid: got %b, want 0", DECONV_VALID); else passed++;
        RST = 1'b0; ENABLE = 1'b0; CFG_WR = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            checks++;
            if (ENABLE40 !== 2'(exp_seq[i]))
                $display("[TB] FAIL rel_phase%0d: got %0d, want %0d", i, ENABLE40, exp_seq[i]);
            else
                passed++;
        end
        checks++; if (FD !== FD_RST) $display("[TB] FAIL rel_fd: got %0d, want %0d", FD, FD_RST); else passed++;
    endtask

    task automatic test_enable_flush();
        int n;
        wait_phase(2'd1);
        checks++; if (DECONV_VALID !== 1'b0) $display("[TB] FAIL idle_valid: got %b, want 0", DECONV_VALID); else passed++;
        ENABLE = 1'b1;
        count_to_valid(n);
        checks++; if (n != 21) $display("[TB] FAIL flush_latency: got %0d cycles, want 21", n); else passed++;
    endtask

    task automatic test_cfg_apply();
        int n;
        wait_phase(2'd0);
        checks++; if (DECONV_VALID !== 1'b1) $display("[TB] FAIL run_valid: got %b, want 1", DECONV_VALID); else passed++;
        CFG_WR = 1'b1; CFG_FD = 6'd40; CFG_FN = 12'd20;
        step();
        CFG_WR = 1'b0;
        checks++; if (CFG_BUSY !== 1'b1) $display("[TB] FAIL cfg_busy_set: got %b, want 1", CFG_BUSY); else passed++;
        checks++; if (FD !== FD_RST) $display("[TB] FAIL cfg_fd_early: got %0d, want %0d", FD, FD_RST); else passed++;
        step();
        checks++; if (FD !== FD_RST) $display("[TB] FAIL cfg_fd_ph2: got %0d, want %0d", FD, FD_RST); else passed++;
        step();
        checks++; if (FD !== 6'd40) $display("[TB] FAIL cfg_fd: got %0d, want 40", FD); else passed++;
        checks++; if (FN !== 12'd20) $display("[TB] FAIL cfg_fn: got %0d, want 20", FN); else passed++;
        checks++; if (CFG_BUSY !== 1'b0) $display("[TB] FAIL cfg_busy_clr: got %b, want 0", CFG_BUSY); else passed++;
        checks++; if (DECONV_VALID !== 1'b0) $display("[TB] FAIL cfg_valid_drop: got %b, want 0", DECONV_VALID); else passed++;
        count_to_valid(n);
        checks++; if (n != 19) $display("[TB] FAIL reflush_latency: got %0d cycles, want 19", n); else passed++;
    endtask

    task automatic test_back_to_back();
        wait_phase(2'd0);
        CFG_WR = 1'b1; CFG_FD = 6'd10; CFG_FN = 12'd1;
        step();
        CFG_FD = 6'd12; CFG_FN = 12'd2;
        step();
        CFG_WR = 1'b0;
        checks++; if (FD !== 6'd40) $display("[TB] FAIL b2b_fd_hold: got %0d, want 40", FD); else passed++;
        step();
        checks++; if (FD !== 6'd12) $display("[TB] FAIL b2b_fd: got %0d, want 12", FD); else passed++;
        checks++; if (FN !== 12'd2) $display("[TB] FAIL b2b_fn: got %0d, want 2", FN); else passed++;
        checks++; if (CFG_BUSY !== 1'b0) $display("[TB] FAIL b2b_busy: got %b, want 0", CFG_BUSY); else passed++;
    endtask

    task automatic test_apply_collision();
        wait_phase(2'd0);
        CFG_WR = 1'b1; CFG_FD = 6'd20; CFG_FN = 12'd3;
        step();
        CFG_WR = 1'b0;
        step();
        CFG_WR = 1'b1; CFG_FD = 6'd22; CFG_FN = 12'd4;
        step();
        CFG_WR = 1'b0;
        checks++; if (FD !== 6'd20) $display("[TB] FAIL coll_fd_old: got %0d, want 20", FD); else passed++;
        checks++; if (CFG_BUSY !== 1'b1) $display("[TB] FAIL coll_busy: got %b, want 1", CFG_BUSY); else passed++;
        step();
        step();
        checks++; if (FD !== 6'd20) $display("[TB] FAIL coll_fd_hold: got %0d, want 20", FD); else passed++;
        step();
        checks++; if (FD !== 6'd22) $display("[TB] FAIL coll_fd_new: got %0d, want 22", FD); else passed++;
        checks++; if (FN !== 12'd4) $display("[TB] FAIL coll_fn_new: got %0d, want 4", FN); else passed++;
        checks++; if (CFG_BUSY !== 1'b0) $display("[TB] FAIL coll_busy_clr: got %b, want 0", CFG_BUSY); else passed++;
    endtask

    task automatic test_enable_drop();
        logic seen;
        wait_phase(2'd0);
        CFG_WR = 1'b1; CFG_FD = 6'd30; CFG_FN = 12'd5;
        step();
        CFG_WR = 1'b0;
        step();
        step();
        checks++; if (FD !== 6'd30) $display("[TB] FAIL drop_fd: got %0d, want 30", FD); else passed++;
        for (int i = 0; i < 10; i++) step();
        ENABLE = 1'b0;
        step();
        checks++; if (DECONV_VALID !== 1'b0) $display("[TB] FAIL drop_valid: got %b, want 0", DECONV_VALID); else passed++;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (DECONV_VALID !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("[TB] FAIL drop_no_run: got valid seen=%b, want 0", seen); else passed++;
    endtask

    task automatic test_idle_apply();
        wait_phase(2'd0);
        CFG_WR = 1'b1; CFG_FD = 6'd33; CFG_FN = 12'd7;
        step();
        CFG_WR = 1'b0;
        step();
        step();
        checks++; if (FD !== 6'd33) $display("[TB] FAIL idle_fd: got %0d, want 33", FD); else passed++;
        checks++; if (FN !== 12'd7) $display("[TB] FAIL idle_fn: got %0d, want 7", FN); else passed++;
        checks++; if (CFG_BUSY !== 1'b0) $display("[TB] FAIL idle_busy: got %b, want 0", CFG_BUSY); else passed++;
        checks++; if (DECONV_VALID !== 1'b0) $display("[TB] FAIL idle_valid2: got %b, want 0", DECONV_VALID); else passed++;
    endtask

    task automatic test_reset_mid_flush();
        ENABLE = 1'b1;
        for (int i = 0; i < 4; i++) step();
        wait_phase(2'd0);
        CFG_WR = 1'b1; CFG_FD = 6'd50; CFG_FN = 12'd9;
        step();
        CFG_WR = 1'b0; RST = 1'b1;
        step();
        RST = 1'b0;
        checks++; if (FD !== FD_RST) $display("[TB] FAIL mrst_fd: got %0d, want %0d", FD, FD_RST); else passed++;
        checks++; if (CFG_BUSY !== 1'b0) $display("[TB] FAIL mrst_busy: got %b, want 0", CFG_BUSY); else passed++;
        checks++; if (ENABLE40 !== 2'd0) $display("[TB] FAIL mrst_phase: got %0d, want 0", ENABLE40); else passed++;
        for (int i = 0; i < 6; i++) step();
        checks++; if (FD !== FD_RST) $display("[TB] FAIL mrst_fd_kept: got %0d, want %0d", FD, FD_RST); else passed++;
        checks++; if (FN !== FN_RST) $display("[TB] FAIL mrst_fn_kept: got %0d, want %0d", FN, FN_RST); else passed++;
    endtask

`ifdef TOTD_DECONV_SAT_COUNT_EN
    task automatic test_sat_count();
        int n;
        count_to_valid(n);
        checks++; if (n < 0) $display("[TB] FAIL sat_run_wait: got %0d, want RUN within 40 cycles", n); else passed++;
        checks++; if (SAT_COUNT !== 16'd0) $display("[TB] FAIL sat_zero: got %0d, want 0", SAT_COUNT); else passed++;
        DATA_IN = 12'd4095;
        for (int i = 0; i < 3 * 70000; i++) step();
        DATA_IN = 12'd0;
        checks++; if (SAT_COUNT !== 16'hFFFF) $display("[TB] FAIL sat_hold: got %0d, want 65535", SAT_COUNT); else passed++;
        SAT_CLR = 1'b1;
        step();
        SAT_CLR = 1'b0;
        checks++; if (SAT_COUNT !== 16'd0) $display("[TB] FAIL sat_clr: got %0d, want 0", SAT_COUNT); else passed++;
    endtask
`endif

    initial begin
        RST = 1'b1; ENABLE = 1'b0; CFG_WR = 1'b0; CFG_FD = '0; CFG_FN = '0; DATA_IN = '0;
`ifdef TOTD_DECONV_SAT_COUNT_EN
        SAT_CLR = 1'b0;
`endif
        $display("[TB] start");
        test_reset();
        test_enable_flush();
        test_cfg_apply();
        test_back_to_back();
        test_apply_collision();
        test_enable_drop();
        test_idle_apply();
        test_reset_mid_flush();
`ifdef TOTD_DECONV_SAT_COUNT_EN
        test_sat_count();
`endif
        step();
        mon_on = 1'b0;
        checks++;
        if (sb_q.size() != 0)
            $display("[TB] FAIL sb_drain: got %0d applies outstanding, want 0", sb_q.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/totd_deconv_ctrl.md
TOTD_DECONV_CTRL -- requirements
Module: totd_deconv_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_TICKS, default 7, meaning the number of 40 MHz ticks the datapath needs to flush after enable or a parameter change.
REQ-002 SHALL have parameter FD_INIT, default 6'd58, meaning the reset value of the FD output.
REQ-003 SHALL have parameter FN_INIT, default 'd16, meaning the reset value of the FN output.
REQ-004 SHALL have port CLK, input, 1 bit: 120 MHz clock; the block uses one clock; reset is synchronous and active-high.
REQ-005 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ENABLE, input, 1 bit: master deconvolution enable.
REQ-007 SHALL have port CFG_WR, input, 1 bit: single-cycle write strobe for a new FD/FN pair.
REQ-008 SHALL have port CFG_FD, input, COMPATIBILITY_TOTD_FD_BITS wide: requested decay constant.
REQ-009 SHALL have port CFG_FN, input, COMPATIBILITY_TOTD_FN_BITS wide: requested normalizer.
REQ-010 SHALL have port DATA_IN, input, ADC_WIDTH wide: deconvolved datapath output, monitored for saturation.
REQ-011 SHALL have port SAT_CLR, input, 1 bit: clears the saturation counter.
REQ-012 SHALL have port ENABLE40, output, 2 bits: 40 MHz phase; the datapath updates when the value is 0.
REQ-013 SHALL have port FD, output, COMPATIBILITY_TOTD_FD_BITS wide: active decay constant.
REQ-014 SHALL have port FN, output, COMPATIBILITY_TOTD_FN_BITS wide: active normalizer.
REQ-015 SHALL have port CFG_BUSY, output, 1 bit: a pending configuration is not yet applied.
REQ-016 SHALL have port DECONV_VALID, output, 1 bit: datapath output is trustworthy.
REQ-017 SHALL have port SAT_COUNT, output, 16 bits: saturation event count; present only with the macro in REQ-033.

Function
REQ-018 SHALL run a phase counter ENABLE40 through the sequence 0,1,2,0,... and SHALL never output the value 3; a "tick" is a cycle in which ENABLE40==0.
REQ-019 SHALL capture CFG_FD and CFG_FN into pending registers and set CFG_BUSY=1 on the cycle after CFG_WR; a CFG_WR while CFG_BUSY=1 SHALL overwrite the pending values (last write wins).
REQ-020 SHALL apply pending values to FD and FN at the first phase-2 cycle strictly after the capturing CFG_WR, so the new values are stable at the next tick, and SHALL clear CFG_BUSY at that same edge.
REQ-021 SHALL, when CFG_WR coincides with an apply cycle, apply the older pending pair, capture the new pair, and keep CFG_BUSY=1 until the next phase-2 cycle.
REQ-022 SHALL keep FD and FN constant at all cycles other than apply edges.
REQ-023 SHALL implement states IDLE, FLUSH and RUN.
REQ-024 SHALL, in IDLE, hold DECONV_VALID=0 and go to FLUSH on ENABLE=1, loading the flush counter with FLUSH_TICKS.
REQ-025 SHALL, in FLUSH, decrement the flush counter on each tick and go to RUN on the tick where the counter reaches 0.
REQ-026 SHALL hold DECONV_VALID=1 only in RUN, asserting it on the cycle after the state enters RUN.
REQ-027 SHALL, on a configuration apply in FLUSH or RUN, enter or re-enter FLUSH and reload the counter with FLUSH_TICKS; an apply in IDLE SHALL cause no state change.
REQ-028 SHALL, when ENABLE=0 in any state, go to IDLE on the next cycle, with DECONV_VALID=0 from that cycle on; ENABLE has priority over an apply.
REQ-029 SHALL allow applies to proceed while ENABLE=0.

Reset
REQ-030 SHALL, on RST=1 at a clock edge, set ENABLE40=0, FD=FD_INIT, FN=FN_INIT, CFG_BUSY=0, DECONV_VALID=0, state=IDLE, flush counter=0, pending registers=0 and SAT_COUNT=0.
REQ-031 SHALL discard any pending configuration on reset, including a reset mid-FLUSH.
REQ-032 SHALL let RST dominate CFG_WR, ENABLE and SAT_CLR.

Configuration
REQ-033 SHALL provide macro TOTD_DECONV_SAT_COUNT_EN; when defined, a 16-bit saturating counter increments on each tick in RUN where DATA_IN==4095, holds at 65535, and is cleared by SAT_CLR, with SAT_CLR dominating a simultaneous increment.
REQ-034 SHALL, when TOTD_DECONV_SAT_COUNT_EN is undefined, omit SAT_COUNT and SAT_CLR and generate no counter logic.

Structure
REQ-035 SHALL place the state enumeration (IDLE/FLUSH/RUN), the phase constants (tick=0, apply=2) and the saturation value 4095 in the shared sde_trigger_defs include.
REQ-036 SHALL isolate the phase counter in a sub-module clk40_phase_gen (CLK, RST -> ENABLE40, TICK, APPLY_PHASE).

Verification
REQ-037 SHALL cover: release reset -> ENABLE40 runs 0,1,2,0,1,2 and FD=58 on the first cycle.
REQ-038 SHALL cover: ENABLE rising at phase 1 -> DECONV_VALID rises after 7 ticks, 21 +/-2 cycles later.
REQ-039 SHALL cover: in RUN, CFG_WR FD=40 FN=20 at phase 0 -> FD=40 after the phase-2 edge, DECONV_VALID drops, and CFG_BUSY clears.
REQ-040 SHALL cover: CFG_WR FD=10 then CFG_WR FD=12 in the next cycle -> only FD=12 is applied; and CFG_WR on an apply cycle -> two applies, 3 cycles apart.
REQ-041 SHALL cover: ENABLE dropped mid-FLUSH with 3 ticks remaining -> IDLE next cycle, DECONV_VALID=0, and no later RUN.
REQ-042 SHALL cover: with the macro, DATA_IN=4095 for 70000 ticks in RUN -> SAT_COUNT=65535; then SAT_CLR -> SAT_COUNT=0.
